// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a program image from a byte stream into the instruction memory's
//   write port while holding the core in reset.
//   Image format: LEN_LO, LEN_HI (word count N), 4*N payload bytes
//   (little-endian words), then CSUM (modulo-256 sum of the payload bytes).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   load_start          one-cycle pulse, starts a load from IDLE/DONE/ERR
//   byte_valid/ready    upstream byte handshake, byte_data carries the byte
//   imem_we/addr/wdata  single-cycle word write into instruction memory
//   cpu_hold            keeps the core in reset while loading or after failure
//   busy                load in progress
//   done, error         sticky completion status, cleared by the next load
module imem_boot_loader #(
    parameter int          DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int MAX_WORDS = DEPTH / 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state_reg,      state_next;
    logic [7:0]  len_lo_reg,     len_lo_next;
    logic [15:0] words_left_reg, words_left_next;
    logic [1:0]  idx_reg,        idx_next;
    logic [7:0]  sum_reg,        sum_next;
    logic [31:0] addr_reg,       addr_next;
    logic [31:0] wdata_reg,      wdata_next;
    logic        busy_reg,       busy_next;
    logic        done_reg,       done_next;
    logic        error_reg,      error_next;
    logic        hold_reg,       hold_next;

    logic        xfer;
    logic [15:0] len_full;
    logic [3:0]  lane_we;

    assign byte_ready = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                        (state_reg == S_DATA)   || (state_reg == S_CSUM);
    assign xfer       = byte_valid && byte_ready;
    assign len_full   = {byte_data, len_lo_reg};

    // One enable per byte lane of the word being assembled.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = (state_reg == S_DATA) && xfer && (idx_reg == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        len_lo_next     = len_lo_reg;
        words_left_next = words_left_reg;
        idx_next        = idx_reg;
        sum_next        = sum_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        error_next      = error_reg;
        hold_next       = hold_reg;

        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                wdata_next[8*i +: 8] = byte_data;
            end
        end

        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_next = S_LEN_LO;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    busy_next  = 1'b1;
                    hold_next  = 1'b1;
                    addr_next  = BASE_ADDR;
                    sum_next   = 8'd0;
                    idx_next   = 2'd0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_next = byte_data;
                    state_next  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
                        // Oversized image: refuse before any write happens.
                        state_next = S_ERR;
                        error_next = 1'b1;
                        busy_next  = 1'b0;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next      = S_DATA;
                        words_left_next = len_full;
                        idx_next        = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    sum_next = sum_reg + byte_data;
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Address advances only after the write cycle so addr/wdata
                // are stable across the whole write, including the negedge.
                addr_next       = addr_reg + 32'd4;
                words_left_next = words_left_reg - 16'd1;
                state_next      = (words_left_reg == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (xfer) begin
                    busy_next = 1'b0;
                    if (byte_data == sum_reg) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        hold_next  = 1'b0;
                    end else begin
                        state_next = S_ERR;
                        error_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            len_lo_reg     <= 8'd0;
            words_left_reg <= 16'd0;
            idx_reg        <= 2'd0;
            sum_reg        <= 8'd0;
            addr_reg       <= BASE_ADDR;
            wdata_reg      <= 32'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            hold_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_lo_reg     <= len_lo_next;
            words_left_reg <= words_left_next;
            idx_reg        <= idx_next;
            sum_reg        <= sum_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            hold_reg       <= hold_next;
        end
    end

    assign imem_we    = (state_reg == S_WRITE);
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_hold   = hold_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream initiator for the 2 KB byte-addressed instruction memory's write port; loads a program image into instruction memory before the core runs.
- Accepts bytes from an upstream byte source (e.g. UART receiver) on a valid/ready handshake, parses a length header, and assembles little-endian 32-bit words.
- Issues one single-cycle write per word, then checks a trailing checksum.
- Holds the core in reset while loading.

Parameters:
- DEPTH, 2048, instruction memory size in bytes; maximum image is DEPTH/4 words.
- BASE_ADDR, 0, byte address of the first word written; multiple of 4.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- load_start  input  1  one-cycle pulse; starts a load from IDLE, DONE or ERR.
- byte_valid  input  1  upstream byte present.
- byte_data  input  8  upstream byte.
- byte_ready  output  1  loader accepts byte_data this cycle; a transfer occurs when byte_valid and byte_ready are both 1 at posedge.
- imem_we  output  1  instruction memory write_enable.
- imem_addr  output  32  instruction memory byte address.
- imem_wdata  output  32  instruction memory write data; byte 0 in [7:0].
- cpu_hold  output  1  holds the core in reset.
- busy  output  1  load in progress.
- done  output  1  sticky; image loaded and checksum OK.
- error  output  1  sticky; length overflow or checksum mismatch.

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, state=IDLE.
- Image format: LEN_LO, LEN_HI (16-bit word count N), then 4N payload bytes (little-endian per word), then CSUM. CSUM = 8-bit modulo-256 sum of all payload bytes.

States:
- IDLE/DONE/ERR: byte_ready=0.
  - load_start → LEN_LO.
  - On entry to LEN_LO: clear done/error, set busy=1 and cpu_hold=1, imem_addr=BASE_ADDR, sum=0.
  - load_start in any other state is ignored.
- LEN_LO: byte_ready=1; on a transfer, latch N[7:0] → LEN_HI.
- LEN_HI: byte_ready=1; on a transfer, latch N[15:8].
  - N > DEPTH/4 → ERR; no writes occur.
  - N = 0 → CSUM.
  - Otherwise → DATA with byte index 0.
- DATA: byte_ready=1; each transfer places the byte into imem_wdata lane [8*idx+7:8*idx] and adds it to sum.
  - The transfer at idx=3 → WRITE.
- WRITE: exactly one cycle; imem_we=1, byte_ready=0.
  - imem_addr and imem_wdata stay stable for the whole cycle, including the negedge on which the memory samples.
  - Next cycle: imem_we=0 and imem_addr += 4.
  - Words remaining → DATA; last word → CSUM.
- CSUM: byte_ready=1; on a transfer, clear busy and compare the byte with sum.
  - Equal → DONE: done=1, cpu_hold=0.
  - Not equal → ERR: error=1, cpu_hold stays 1.

Timing and boundary rules:
- Write latency: imem_we asserts in the cycle after the posedge that accepts a word's 4th byte.
- Minimum throughput: 5 cycles per word with back-to-back bytes.
- byte_valid=0 mid-word stalls indefinitely with no timeout; partial-word state is held.
- Maximum image: N = DEPTH/4 = 512 is legal. The last write address is BASE_ADDR+2044; imem_addr reaches BASE_ADDR+2048 afterwards with no write issued there.
- Address arithmetic is 32-bit unsigned. The address counter is not reset between words, only at load_start.
- Reset mid-load: return to reset values immediately. Words already written remain in memory; no rollback.
- A byte presented while byte_ready=0 is not consumed; the upstream source must hold it.

Test Plan:
- Load N=2, payload 13 00 00 00 93 00 10 00, CSUM=0xB6 → writes 0x00000013 @0 then 0x00100093 @4, one cycle each; done=1, cpu_hold=0, error=0.
- LEN=0x0201 (513 > 512) → ERR next cycle, no imem_we pulse ever, error=1, cpu_hold=1, byte_ready=0.
- N=1, bytes AA BB CC DD, CSUM=0x00 (sum is 0x0E) → write 0xDDCCBBAA @BASE_ADDR, then error=1, done=0, cpu_hold stays 1.
- N=1 with byte_valid dropped for 7 cycles between bytes 2 and 3 → no write until byte 3 is accepted; correct word written; byte_ready=0 only during the WRITE cycle.
- N=0, CSUM=0x00 → done=1 with no writes. A new load_start from DONE clears done and restarts at BASE_ADDR.
- rst=1 after two of four words written → all outputs at reset values next cycle, state=IDLE; a subsequent full load succeeds.
